// File: rtl/fpu_issue.sv
// fpu_issue: core-side initiator for the FPU order/accepted/done protocol.
// Optional FPU_ISSUE_TIMEOUT_EN adds an order-to-done watchdog with sticky err.

package fpu_pkg;
  localparam int LEN_FUNC3 = 3;
  localparam int LEN_FUNC7 = 7;
  localparam int LEN_WORD  = 32;
  localparam logic [LEN_FUNC7-1:0] FUNC7_FCOMP = 7'b1010000;
  localparam logic [LEN_FUNC7-1:0] FUNC7_FTOI  = 7'b1100000;
  localparam logic [LEN_FUNC7-1:0] FUNC7_FMVI  = 7'b1110000;
endpackage

module fpu_issue
  import fpu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [LEN_FUNC3-1:0] req_func3,
  input  logic [LEN_FUNC7-1:0] req_func7,
  input  logic [LEN_WORD-1:0]  req_rs1,
  input  logic [LEN_WORD-1:0]  req_rs2,
  input  logic [4:0]           req_rd_addr,
  output logic                 order,
  output logic [LEN_FUNC3-1:0] func3,
  output logic [LEN_FUNC7-1:0] func7,
  output logic [LEN_WORD-1:0]  rs1,
  output logic [LEN_WORD-1:0]  rs2,
  input  logic                 accepted,
  input  logic                 done,
  input  logic [LEN_WORD-1:0]  rd,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [LEN_WORD-1:0]  wb_data,
  output logic [4:0]           wb_addr,
  output logic                 wb_to_int,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t state;
  state_t nxt;

  logic take;
  logic inflight;
  logic capture;
  logic to_int_d;
  logic tmo;

  assign take     = (state == IDLE) && req_valid;
  assign inflight = (state == ISSUE) || (state == WAIT);
  assign capture  = inflight && done;

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign tmo = inflight && !done
            && (cnt == CW'(TIMEOUT - 1));

  // Watchdog: cleared on issue, counts every ISSUE/WAIT cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (take) begin
      cnt <= '0;
    end else if (inflight) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Sticky error once the FPU fails to finish in time
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if (tmo) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  // Results headed for the integer register file
  always_comb begin
    to_int_d = 1'b0;
    unique case (1'b1)
      req_func7 == FUNC7_FCOMP: to_int_d = 1'b1;
      req_func7 == FUNC7_FTOI:  to_int_d = 1'b1;
      req_func7 == FUNC7_FMVI:  to_int_d = 1'b1;
      default:                  to_int_d = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next state; done wins over accepted and over expiry
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (req_valid) nxt = ISSUE;
      ISSUE: begin
        if (done) nxt = WB;
        else if (tmo) nxt = IDLE;
        else if (accepted) nxt = WAIT;
      end
      WAIT: begin
        if (done) nxt = WB;
        else if (tmo) nxt = IDLE;
      end
      WB:    if (wb_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    req_ready = (state == IDLE);
    order     = (state == ISSUE);
    wb_valid  = (state == WB);
    busy      = (state != IDLE);
  end

  // Operand latch; only moves on IDLE->ISSUE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      func3     <= '0;
      func7     <= '0;
      rs1       <= '0;
      rs2       <= '0;
      wb_addr   <= '0;
      wb_to_int <= 1'b0;
    end else if (take) begin
      func3     <= req_func3;
      func7     <= req_func7;
      rs1       <= req_rs1;
      rs2       <= req_rs2;
      wb_addr   <= req_rd_addr;
      wb_to_int <= to_int_d;
    end
  end

  // Result capture while an op is in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_data <= '0;
    end else if (capture) begin
      wb_data <= rd;
    end
  end

endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: directed checks of fpu_issue handshakes.
// Timeout section runs only when FPU_ISSUE_TIMEOUT_EN is defined.

module tb_fpu_issue;
  import fpu_pkg::*;

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_func3;
  logic [6:0]  req_func7;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd_addr;
  logic        order;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        accepted;
  logic        done;
  logic [31:0] rd;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_to_int;
  logic        busy;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;

  fpu_issue #(.TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_func3(req_func3), .req_func7(req_func7),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rd_addr(req_rd_addr),
    .order(order), .func3(func3), .func7(func7),
    .rs1(rs1), .rs2(rs2),
    .accepted(accepted), .done(done), .rd(rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_addr(wb_addr),
    .wb_to_int(wb_to_int), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [6:0] f7,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [4:0] ad);
    req_valid   = 1'b1;
    req_func3   = 3'd1;
    req_func7   = f7;
    req_rs1     = a;
    req_rs2     = b;
    req_rd_addr = ad;
  endtask

  initial begin
    rstn = 1'b0;
    req_valid = 1'b0;
    req_func3 = '0;
    req_func7 = '0;
    req_rs1 = '0;
    req_rs2 = '0;
    req_rd_addr = '0;
    accepted = 1'b0;
    done = 1'b0;
    rd = '0;
    wb_ready = 1'b1;

    step();
    step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_order", 32'(order), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_wb_to_int", 32'(wb_to_int), 32'd0);
    chk("rst_rs1", rs1, 32'd0);
    chk("rst_func7", 32'(func7), 32'd0);
    rstn = 1'b1;
    step();

    // fmvi, single-cycle FPU
    req(FUNC7_FMVI, 32'h3F800000, 32'h0, 5'd5);
    chk("t1_c0_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("t1_c1_order", 32'(order), 32'd1);
    chk("t1_c1_rs1", rs1, 32'h3F800000);
    chk("t1_c1_busy", 32'(busy), 32'd1);
    chk("t1_c1_wbv", 32'(wb_valid), 32'd0);
    accepted = 1'b1;
    done = 1'b1;
    rd = 32'h3F800000;
    step();
    accepted = 1'b0;
    done = 1'b0;
    rd = 32'hDEADBEEF;
    chk("t1_c2_order", 32'(order), 32'd0);
    chk("t1_c2_wbv", 32'(wb_valid), 32'd1);
    chk("t1_c2_data", wb_data, 32'h3F800000);
    chk("t1_c2_to_int", 32'(wb_to_int), 32'd1);
    chk("t1_c2_addr", 32'(wb_addr), 32'd5);
    step();
    chk("t1_c3_wbv", 32'(wb_valid), 32'd0);
    chk("t1_c3_ready", 32'(req_ready), 32'd1);

    // done/accepted in IDLE are ignored
    done = 1'b1;
    accepted = 1'b1;
    rd = 32'hBADBAD00;
    step();
    done = 1'b0;
    accepted = 1'b0;
    chk("idle_ign_ready", 32'(req_ready), 32'd1);
    chk("idle_ign_data", wb_data, 32'h3F800000);

    // fadd, accepted c1, done c5
    req(7'h00, 32'h3F800000, 32'h40000000, 5'd3);
    step();
    req_valid = 1'b0;
    req_rs1 = 32'h11111111;
    req_rs2 = 32'h22222222;
    chk("t2_c1_order", 32'(order), 32'd1);
    accepted = 1'b1;
    step();
    accepted = 1'b0;
    chk("t2_c2_order", 32'(order), 32'd0);
    chk("t2_c2_busy", 32'(busy), 32'd1);
    chk("t2_c2_rs1", rs1, 32'h3F800000);
    step();
    step();
    chk("t2_c4_rs2", rs2, 32'h40000000);
    chk("t2_c4_wbv", 32'(wb_valid), 32'd0);
    step();
    chk("t2_c5_rs1", rs1, 32'h3F800000);
    chk("t2_c5_rs2", rs2, 32'h40000000);
    done = 1'b1;
    rd = 32'h40400000;
    step();
    done = 1'b0;
    chk("t2_c6_wbv", 32'(wb_valid), 32'd1);
    chk("t2_c6_data", wb_data, 32'h40400000);
    chk("t2_c6_to_int", 32'(wb_to_int), 32'd0);
    chk("t2_c6_addr", 32'(wb_addr), 32'd3);
    step();

    // accepted held low 3 cycles, then wb stall
    req(FUNC7_FTOI, 32'hC0000000, 32'h0, 5'd7);
    step();
    req_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("t3_c%0d_order", i), 32'(order), 32'd1);
      chk($sformatf("t3_c%0d_ready", i), 32'(req_ready), 32'd0);
      step();
    end
    chk("t3_c4_order", 32'(order), 32'd1);
    accepted = 1'b1;
    step();
    accepted = 1'b0;
    chk("t3_c5_order", 32'(order), 32'd0);
    done = 1'b1;
    rd = 32'h12345678;
    wb_ready = 1'b0;
    step();
    done = 1'b0;
    rd = 32'h0;
    req(FUNC7_FCOMP, 32'hAAAA5555, 32'h5555AAAA, 5'd9);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_s%0d_wbv", i), 32'(wb_valid), 32'd1);
      chk($sformatf("t4_s%0d_data", i), wb_data, 32'h12345678);
      chk($sformatf("t4_s%0d_ready", i), 32'(req_ready), 32'd0);
      if (i == 3) wb_ready = 1'b1;
      step();
    end
    chk("t3_to_int", 32'(wb_to_int), 32'd1);
    chk("t4_idle_ready", 32'(req_ready), 32'd1);
    chk("t4_idle_wbv", 32'(wb_valid), 32'd0);
    step();
    req_valid = 1'b0;
    chk("t4_new_order", 32'(order), 32'd1);
    chk("t4_new_rs1", rs1, 32'hAAAA5555);
    accepted = 1'b1;
    step();
    accepted = 1'b0;
    chk("t5_wait_order", 32'(order), 32'd0);
    chk("t5_wait_busy", 32'(busy), 32'd1);

    // asynchronous reset from WAIT
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_rst_order", 32'(order), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_wbv", 32'(wb_valid), 32'd0);
    chk("t5_rst_data", wb_data, 32'd0);
    step();
    rstn = 1'b1;
    req(7'h20, 32'h01020304, 32'h0, 5'd2);
    chk("t5_post_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("t5_post_order", 32'(order), 32'd1);
    done = 1'b1;
    rd = 32'h0A0B0C0D;
    step();
    done = 1'b0;
    chk("t5_post_wbv", 32'(wb_valid), 32'd1);
    chk("t5_post_data", wb_data, 32'h0A0B0C0D);
    chk("t5_post_to_int", 32'(wb_to_int), 32'd0);
    step();

`ifdef FPU_ISSUE_TIMEOUT_EN
    req(7'h00, 32'h1, 32'h2, 5'd4);
    step();
    req_valid = 1'b0;
    accepted = 1'b1;
    step();
    accepted = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      chk($sformatf("to_c%0d_err", i), 32'(err), 32'd0);
      chk($sformatf("to_c%0d_busy", i), 32'(busy), 32'd1);
      step();
    end
    chk("to_err", 32'(err), 32'd1);
    chk("to_idle", 32'(req_ready), 32'd1);
    chk("to_wbv", 32'(wb_valid), 32'd0);
    step();
    chk("to_err_sticky", 32'(err), 32'd1);
    chk("to_wbv2", 32'(wb_valid), 32'd0);
`else
    chk("err_tied", 32'(err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_issue.md
# fpu_issue

Core-side initiator for the FPU order/accepted/done protocol. It takes one floating-point instruction at a time from the execute stage and latches its operands. It drives the FPU's order, func3, func7, rs1 and rs2 inputs and holds them stable until done. It then captures the FPU result and presents it to writeback through a valid/ready handshake, routing it to the integer or float register file.

## Interface
- `TIMEOUT`, 255: max cycles from order to done before abort (used only with `FPU_ISSUE_TIMEOUT_EN`); counter width is `$clog2(TIMEOUT+1)`.
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous and active-low.
- req_valid  in  1  execute stage presents an FPU instruction.
- req_ready  out  1  block can take a request (high only in IDLE).
- req_func3  in  `LEN_FUNC3`  instruction func3.
- req_func7  in  `LEN_FUNC7`  instruction func7.
- req_rs1, req_rs2  in  `LEN_WORD` each  source operands.
- req_rd_addr  in  5  destination register index.
- order  out  1  to FPU: start operation.
- func3, func7, rs1, rs2  out  as above  to FPU: latched operands.
- accepted  in  1  from FPU: order taken this cycle.
- done  in  1  from FPU: result valid on `rd` this cycle.
- rd  in  `LEN_WORD`  FPU result.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback consumes result.
- wb_data  out  `LEN_WORD`  captured result.
- wb_addr  out  5  destination index.
- wb_to_int  out  1  destination is the integer register file.
- busy  out  1  state ≠ IDLE; used as a stall signal.
- err  out  1  sticky timeout flag (constant 0 without `FPU_ISSUE_TIMEOUT_EN`).

## Operation
- FSM states: IDLE, ISSUE, WAIT, WB.
- **IDLE**
  - req_ready=1.
  - On req_valid: latch func3, func7, rs1, rs2 and rd_addr; compute wb_to_int; go to ISSUE.
- **ISSUE**
  - order=1 with the latched operands.
  - done (with or without accepted): capture rd into wb_data, go to WB.
  - accepted without done: go to WAIT.
  - Neither: stay in ISSUE, order stays high.
- **WAIT**
  - order=0; operands held stable.
  - done: capture rd, go to WB.
- **WB**
  - wb_valid=1; wb_data, wb_addr and wb_to_int held stable.
  - wb_ready: go to IDLE.
- wb_to_int=1 iff the latched func7 is `FUNC7_FCOMP`, `FUNC7_FTOI` or `FUNC7_FMVI`; 0 for every other func7.
- done or accepted seen in IDLE or WB is ignored; no state change, no capture.
- Operand outputs change only on the IDLE→ISSUE transition.

## Timing
- Reset (rstn=0, asynchronous): state=IDLE, order=0, wb_valid=0, wb_data=0, wb_addr=0, wb_to_int=0, err=0, busy=0, latched operands 0; req_ready=1 once state is IDLE.
- Reset mid-operation: order drops immediately and the in-flight result is lost. The FPU is reset by the same rstn.
- Latency:
  - req accepted in cycle 0; order high in cycle 1.
  - Same-cycle FPU op (done in cycle 1): wb_valid in cycle 2.
  - General case: wb_valid is high 1 cycle after done.
- Throughput: with wb_ready tied high, next req_ready comes 1 cycle after wb_valid, so 3 cycles per single-cycle op.
- order is high for at least 1 cycle and stays high until accepted or done.
- done and accepted in the same ISSUE cycle: treated as done; WAIT is skipped.

## Configuration
- Macro: `FPU_ISSUE_TIMEOUT_EN`.
- Defined:
  - A counter clears on IDLE→ISSUE and increments in ISSUE and WAIT.
  - When it reaches `TIMEOUT` without done: set err (sticky until reset), drop order, return to IDLE, no wb_valid.
  - done in the expiry cycle has priority: normal capture, no err.
- Undefined: no counter, err tied 0, the FSM waits indefinitely.

## Test plan
- fmvi (func7=`FUNC7_FMVI`), rs1=0x3F800000, FPU gives accepted=done=1 in the first order cycle, wb_ready=1 -> order high exactly 1 cycle; wb_valid 2 cycles after the req handshake; wb_data=0x3F800000; wb_to_int=1.
- fadd with a model FPU asserting accepted in cycle 1 and done in cycle 5 with rd=0x40400000 -> order low from cycle 2; rs1/rs2 stable through cycle 5; wb_valid in cycle 6; wb_to_int=0.
- accepted held low for 3 cycles -> order stays high 4 cycles; state stays ISSUE; req_ready=0 throughout.
- wb_ready low for 4 cycles during WB -> wb_valid and wb_data held; a new req_valid is not accepted until 1 cycle after wb_ready.
- rstn pulsed low while in WAIT -> order=0, busy=0, wb_valid=0 immediately; next req accepted normally.
- With `FPU_ISSUE_TIMEOUT_EN`, `TIMEOUT`=8, FPU never signals done -> err rises after 8 cycles in ISSUE/WAIT; returns to IDLE; no wb_valid; err stays 1.
